// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: DEPTH-entry queue, up to MAX_OUT in-order IO requests in flight.
// Optional macro IFU_BYPASS_EN forwards a response straight to the consumer when the queue is empty.
module ifu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_respValid,
  input  logic [31:0] io_rdata,
  output logic [31:0] io_addr,
  output logic        io_reqValid,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = ((CW > 3) ? CW : 3) + 1;

  typedef enum logic [1:0] {IFU_IDLE, IFU_FETCH, IFU_DRAIN} state_t;

  state_t          state, state_next;
  logic [31:0]     fetch_pc, resp_pc;
  logic [31:0]     q_inst [DEPTH];
  logic [31:0]     q_pc   [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [2:0]      inflight, inflight_next, drop, drop_next;
  logic            issue, accept, push, pop, bypass, head_valid;

  // Every outstanding request already owns a queue slot, so pushes can never overflow.
  assign issue = (state == IFU_FETCH) && !redirect_valid &&
                 (inflight < 3'(MAX_OUT)) &&
                 ((SW'(count) + SW'(inflight)) < SW'(DEPTH));

  assign accept     = io_respValid && (drop == 3'd0) && !redirect_valid;
  assign head_valid = (count != '0) && !redirect_valid;

`ifdef IFU_BYPASS_EN
  assign bypass = accept && (count == '0) && respReady;
`else
  assign bypass = 1'b0;
`endif

  assign push          = accept && !bypass;
  assign pop           = head_valid && respReady;
  assign inflight_next = inflight + 3'(issue) - 3'(io_respValid);

  assign io_reqValid = issue;
  assign io_addr     = fetch_pc;
  assign respValid   = head_valid || bypass;
  assign inst        = bypass ? io_rdata : q_inst[rd_ptr];
  assign inst_pc     = bypass ? resp_pc  : q_pc[rd_ptr];

  // A redirect discards everything still outstanding once this cycle's response is accounted for.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    if (redirect_valid)
      drop_next = inflight_next;
    else if (io_respValid && (drop != 3'd0))
      drop_next = drop - 3'd1;

    case (state)
      IFU_IDLE:  if (enable) state_next = IFU_FETCH;
      IFU_FETCH: if (!enable) state_next = IFU_IDLE;
      IFU_DRAIN: if (drop_next == 3'd0) state_next = enable ? IFU_FETCH : IFU_IDLE;
      default:   state_next = IFU_IDLE;
    endcase

    if (redirect_valid)
      state_next = (drop_next != 3'd0) ? IFU_DRAIN : (enable ? IFU_FETCH : IFU_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IFU_IDLE;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 3'd0;
      drop     <= 3'd0;
    end else begin
      state    <= state_next;
      inflight <= inflight_next;
      drop     <= drop_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (issue)  fetch_pc <= fetch_pc + 32'd4;
        if (accept) resp_pc  <= resp_pc + 32'd4;
        if (push)   wr_ptr   <= wr_ptr + 1'b1;
        if (pop)    rd_ptr   <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

  // Queue storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clock) begin
    if (push) begin
      q_inst[wr_ptr] <= io_rdata;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(push && !pop && (count == CW'(DEPTH))));
      assert (!(pop && (count == '0)));
    end
  end
`endif

endmodule
